reverb_delay_line_master: RTL and testbench

- Avalon-MM master that drives the second port of the reverb on-chip delay memory.
- Memory geometry: 64-bit words, 18-bit address, 250000 words.
- Per audio frame: writes one stereo input word at a circular write pointer, then reads NUM_TAPS delayed words and presents them to the reverb datapath as one tap vector.
- Zero-fills the memory after reset so that the reverb tail starts silent.

---
 rtl/reverb_delay_line_master.sv | 183 ++++++++++++++++++
 tb/tb_reverb_delay_line_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reverb_delay_line_master.sv
// Avalon-MM master for the reverb delay memory: zero-fills after reset, then per frame
// writes one stereo word at a circular pointer and reads NUM_TAPS delayed words.
module reverb_delay_line_master #(
    parameter int DEPTH    = 250000,
    parameter int AW       = 18,
    parameter int DW       = 64,
    parameter int NUM_TAPS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_TAPS*AW-1:0] tap_delay,
    output logic [NUM_TAPS*DW-1:0] taps_data,
    output logic                   taps_valid,
    input  logic                   taps_ready,
    output logic                   init_done,
    output logic [AW-1:0]          avm_address,
    output logic                   avm_chipselect,
    output logic                   avm_write,
    output logic [DW-1:0]          avm_writedata,
    output logic [DW/8-1:0]        avm_byteenable,
    input  logic [DW-1:0]          avm_readdata
);
    localparam int              CW        = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   DEPTH_A   = AW'(DEPTH);
    localparam logic [AW:0]     INIT_END  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]   LAST_TAP  = CW'(NUM_TAPS - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_CAPTURE, S_OUT} state_t;

    state_t         state, state_next;
    logic [AW:0]    init_cnt, init_cnt_next;
    logic [AW-1:0]  wr_ptr, wr_ptr_next;
    logic [CW-1:0]  tap_cnt, tap_cnt_next, next_idx;
    logic [AW-1:0]  delay_q [NUM_TAPS];
    logic [DW-1:0]  taps_q  [NUM_TAPS];

    logic           in_ready_next, taps_valid_next, init_done_next;
    logic           cs_next, wr_next;
    logic [AW-1:0]  addr_next;
    logic [DW-1:0]  wdata_next;

    function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] d);
        return (d > LAST_ADDR) ? LAST_ADDR : d;
    endfunction

    // (ptr - d) mod DEPTH without a wider adder: d <= DEPTH-1 keeps DEPTH-d in range.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] ptr, input logic [AW-1:0] d);
        if (ptr >= d) return ptr - d;
        return ptr + (DEPTH_A - d);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Bus and handshake outputs are registered so they are clean zero during reset.
    always_comb begin
        state_next      = state;
        init_cnt_next   = init_cnt;
        wr_ptr_next     = wr_ptr;
        tap_cnt_next    = tap_cnt;
        in_ready_next   = in_ready;
        taps_valid_next = taps_valid;
        init_done_next  = init_done;
        cs_next         = 1'b0;
        wr_next         = 1'b0;
        addr_next       = avm_address;
        wdata_next      = avm_writedata;
        next_idx        = tap_cnt + 1'b1;
        case (state)
            S_INIT: begin
                if (init_cnt != INIT_END) begin
                    cs_next       = 1'b1;
                    wr_next       = 1'b1;
                    addr_next     = init_cnt[AW-1:0];
                    wdata_next    = '0;
                    init_cnt_next = init_cnt + 1'b1;
                end else begin
                    state_next     = S_IDLE;
                    init_done_next = 1'b1;
                    in_ready_next  = 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_next    = S_WRITE;
                    in_ready_next = 1'b0;
                    cs_next       = 1'b1;
                    wr_next       = 1'b1;
                    addr_next     = wr_ptr;
                    wdata_next    = in_data;
                end
            end
            S_WRITE: begin
                state_next   = S_READ;
                tap_cnt_next = '0;
                cs_next      = 1'b1;
                addr_next    = tap_addr(wr_ptr, delay_q[0]);
            end
            S_READ: begin
                if (tap_cnt != LAST_TAP) begin
                    tap_cnt_next = next_idx;
                    cs_next      = 1'b1;
                    addr_next    = tap_addr(wr_ptr, delay_q[next_idx]);
                end else begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next      = S_OUT;
                taps_valid_next = 1'b1;
                wr_ptr_next     = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            S_OUT: begin
                if (taps_ready) begin
                    state_next      = S_IDLE;
                    taps_valid_next = 1'b0;
                    in_ready_next   = 1'b1;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt       <= '0;
            wr_ptr         <= '0;
            tap_cnt        <= '0;
            in_ready       <= 1'b0;
            taps_valid     <= 1'b0;
            init_done      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                delay_q[k] <= '0;
                taps_q[k]  <= '0;
            end
        end else begin
            init_cnt       <= init_cnt_next;
            wr_ptr         <= wr_ptr_next;
            tap_cnt        <= tap_cnt_next;
            in_ready       <= in_ready_next;
            taps_valid     <= taps_valid_next;
            init_done      <= init_done_next;
            avm_chipselect <= cs_next;
            avm_write      <= wr_next;
            avm_address    <= addr_next;
            avm_writedata  <= wdata_next;
            if (state == S_IDLE && in_valid && in_ready) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    delay_q[k] <= clamp_delay(tap_delay[k*AW +: AW]);
                end
            end
            // Read data trails its address by one cycle, so tap k-1 lands during read k.
            if (state == S_READ && tap_cnt != '0) begin
                taps_q[tap_cnt - 1'b1] <= avm_readdata;
            end
            if (state == S_CAPTURE) begin
                taps_q[LAST_TAP] <= avm_readdata;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            taps_data[k*DW +: DW] = taps_q[k];
        end
    end

    assign avm_byteenable = '1;

endmodule

// File: tb/tb_reverb_delay_line_master.sv
// Bench for reverb_delay_line_master: behavioural memory, bus monitor and an array-based
// reference model of the circular delay line; directed phases with randomized frames.
module tb_reverb_delay_line_master;
  localparam int DEPTH = 16;
  localparam int AW    = 18;
  localparam int DW    = 64;
  localparam int NT    = 4;
  localparam int MW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NT*AW-1:0]  tap_delay = '0;
  logic [NT*DW-1:0]  taps_data;
  logic              taps_valid;
  logic              taps_ready = 1'b1;
  logic              init_done;
  logic [AW-1:0]     avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [DW-1:0]     avm_writedata;
  logic [DW/8-1:0]   avm_byteenable;
  logic [DW-1:0]     avm_readdata;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } bus_t;

  bus_t           bus_q[$];
  logic [AW-1:0]  exp_q[$];
  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  ref_mem [DEPTH];
  int             ref_ptr;
  int             cyc = 0;
  int             checks = 0;
  int             failures = 0;
  logic [NT*DW-1:0] got_taps;
  logic [AW-1:0]  last_write_addr;

  reverb_delay_line_master #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NUM_TAPS(NT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tap_delay(tap_delay), .taps_data(taps_data), .taps_valid(taps_valid),
    .taps_ready(taps_ready), .init_done(init_done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // memory: registered read, junk on the read bus whenever no read was issued
  always @(posedge clk) begin
    if (avm_chipselect && avm_write) mem[avm_address[MW-1:0]] <= avm_writedata;
    if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address[MW-1:0]];
    else avm_readdata <= {$urandom, $urandom};
  end

  // bus monitor
  always @(negedge clk) begin
    if (!reset && avm_chipselect) bus_q.push_back('{avm_write, avm_address, avm_writedata, cyc});
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NT*DW-1:0] obs, input logic [NT*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [NT*AW-1:0] rand_delays();
    logic [NT*AW-1:0] td;
    for (int k = 0; k < NT; k++) td[k*AW +: AW] = AW'($urandom_range(0, 40));
    return td;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_taps_valid"}, taps_valid, 0);
    check({tag, "_taps_data"}, taps_data, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_avm_cs_wr"}, {avm_chipselect, avm_write}, 0);
    check({tag, "_avm_addr_wdata"}, {avm_address, avm_writedata}, 0);
  endtask

  // driver: reset, then verify the zero-fill and the input hold-off
  task automatic reset_and_init(input bit valid_during_init);
    int n, good, done_cyc;
    bit held_off;
    reset = 1'b1;
    in_valid = 1'b0;
    taps_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    bus_q.delete();
    in_valid = valid_during_init;
    in_data = {$urandom, $urandom};
    reset = 1'b0;
    n = 0;
    held_off = 1'b1;
    while (init_done !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (init_done !== 1'b1 && in_ready !== 1'b0) held_off = 1'b0;
    end
    in_valid = 1'b0;
    done_cyc = cyc - 1;
    check("init_done_reached", init_done, 1);
    check("in_ready_after_init", in_ready, 1);
    check("input_held_off_during_init", held_off, 1);
    check("zero_fill_count", bus_q.size(), DEPTH);
    good = 0;
    for (int i = 0; i < bus_q.size() && i < DEPTH; i++)
      if (bus_q[i].wr === 1'b1 && bus_q[i].addr === AW'(i) && bus_q[i].data === '0 &&
          bus_q[i].cyc == bus_q[0].cyc + i) good++;
    check("zero_fill_entries", good, DEPTH);
    if (bus_q.size() > 0) check("init_done_timing", done_cyc, bus_q[bus_q.size()-1].cyc + 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_ptr = 0;
  endtask

  // driver + scoreboard for one frame; hold>0 keeps taps_ready low for that many cycles in OUT
  task automatic run_frame(input logic [DW-1:0] data, input logic [NT*AW-1:0] td, input int hold);
    int n, lat, dk, a, acc;
    logic [NT*DW-1:0] exp_taps;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("in_ready_idle", in_ready, 1);
    ref_mem[ref_ptr] = data;
    exp_q.delete();
    exp_taps = '0;
    for (int k = 0; k < NT; k++) begin
      dk = int'(td[k*AW +: AW]);
      if (dk > DEPTH - 1) dk = DEPTH - 1;
      a = (ref_ptr - dk + DEPTH) % DEPTH;
      exp_q.push_back(AW'(a));
      exp_taps[k*DW +: DW] = ref_mem[a];
    end
    taps_ready = (hold == 0);
    bus_q.delete();
    in_data = data;
    tap_delay = td;
    in_valid = 1'b1;
    acc = cyc;
    tick();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    tap_delay = rand_delays();
    lat = 1;
    while (taps_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
    check("taps_latency", lat, NT + 3);
    check("taps_data", taps_data, exp_taps);
    check("access_count", bus_q.size(), NT + 1);
    if (bus_q.size() == NT + 1) begin
      check("write_cycle", bus_q[0].cyc, acc);
      check("write_addr", bus_q[0].addr, AW'(ref_ptr));
      check("write_flag_data", {bus_q[0].wr, bus_q[0].data}, {1'b1, data});
      for (int k = 0; k < NT; k++) begin
        check("read_addr", bus_q[k+1].addr, exp_q[k]);
        check("read_flag_cycle", {bus_q[k+1].wr, 32'(bus_q[k+1].cyc)}, {1'b0, 32'(acc + k + 1)});
      end
      last_write_addr = bus_q[0].addr;
    end
    got_taps = taps_data;
    ref_ptr = (ref_ptr + 1) % DEPTH;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_state", {taps_valid, in_ready, avm_chipselect}, 3'b100);
        check("hold_taps_stable", taps_data, exp_taps);
      end
      check("hold_no_access", bus_q.size(), NT + 1);
      taps_ready = 1'b1;
    end
    tick();
    check("back_to_idle", {taps_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [NT*AW-1:0] td;
    logic [DW-1:0]    v;
    int p;

    // Phase A: first frame after zero-fill, delays {0,1,2,3}
    reset_and_init(1'b1);
    check("byteenable", avm_byteenable, 8'hFF);
    td = {AW'(3), AW'(2), AW'(1), AW'(0)};
    run_frame(64'h00000001_00000002, td, 0);
    check("first_frame_taps", got_taps, {64'h0, 64'h0, 64'h0, 64'h00000001_00000002});
    check("first_frame_write_addr", last_write_addr, 0);

    // Phase B: wrap-around with 20 frames of value n, delay 3 on every tap
    reset_and_init(1'b0);
    td = {NT{AW'(3)}};
    for (int n = 0; n < 20; n++) run_frame(64'(n), td, 0);
    check("wrap_write_addr", last_write_addr, 3);
    check("wrap_taps", got_taps, {NT{64'd16}});

    // Phase C: oversized delays clamp to DEPTH-1, random frames, and a stalled output
    p = ref_ptr;
    td = {NT{AW'(40)}};
    v = {$urandom, $urandom};
    run_frame(v, td, 0);
    check("clamp_read_addr", exp_q[0], AW'((p + 1) % DEPTH));
    for (int n = 0; n < 24; n++) begin
      v = {$urandom, $urandom};
      run_frame(v, rand_delays(), (n == 7) ? 10 : 0);
    end
    check("init_done_sticky", init_done, 1);

    // Phase D: reset in the middle of frame 5's reads
    reset_and_init(1'b0);
    for (int n = 0; n < 5; n++) run_frame({$urandom, $urandom}, rand_delays(), 0);
    in_data = {$urandom, $urandom};
    tap_delay = rand_delays();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_frame_reset");
    reset_and_init(1'b0);
    v = {$urandom, $urandom};
    run_frame(v, rand_delays(), 0);
    check("post_reset_write_addr", last_write_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
